// File: rtl/pwm_pkg.sv
// Shared types for the multi-channel PWM: counting mode and counter direction.
package pwm_pkg;

  typedef enum logic {
    PwmEdge   = 1'b0,
    PwmCenter = 1'b1
  } pwm_mode_e;

  typedef enum logic {
    CntUp   = 1'b0,
    CntDown = 1'b1
  } cnt_dir_e;

endpackage

// File: rtl/pwm_chan.sv
// One PWM channel: shadowed width/polarity, compare against the shared counter,
// registered output.
module pwm_chan
  import pwm_pkg::*;
#(
  parameter int CtrSize = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic               run_i,
  input  logic [CtrSize-1:0] count_i,
  input  logic [CtrSize-1:0] width_i,
  input  logic               invert_i,
  output logic               out_o
);

  logic [CtrSize-1:0] width_q, width_d;
  logic               invert_q, invert_d;
  logic               out_q, out_d;

  always_comb begin
    width_d  = load_i ? width_i : width_q;
    invert_d = load_i ? invert_i : invert_q;
    // While stopped the output rests at the idle polarity.
    out_d    = run_i ? ((width_q > count_i) ^ invert_q) : invert_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      width_q  <= '0;
      invert_q <= 1'b0;
      out_q    <= 1'b0;
    end else begin
      width_q  <= width_d;
      invert_q <= invert_d;
      out_q    <= out_d;
    end
  end

  assign out_o = out_q;

endmodule

// File: rtl/pwm_mc.sv
// Multi-channel PWM with one shared edge/center-aligned counter and
// boundary-synchronised shadow register updates.
module pwm_mc
  import pwm_pkg::*;
#(
  parameter int NumChannels = 4,
  parameter int CtrSize     = 8
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                enable_i,
  input  logic                                center_i,
  input  logic [CtrSize-1:0]                  max_counter_i,
  input  logic [NumChannels-1:0][CtrSize-1:0] pulse_width_i,
  input  logic [NumChannels-1:0]              invert_i,
  input  logic                                update_i,
  output logic                                update_ack_o,
  output logic                                period_start_o,
  output logic [NumChannels-1:0]              modulated_o
);

  localparam logic [CtrSize-1:0] One = CtrSize'(1);

  logic [CtrSize-1:0] cnt_q, cnt_d;
  logic [CtrSize-1:0] max_q, max_d;
  cnt_dir_e           dir_q, dir_d;
  pwm_mode_e          mode_q, mode_d;
  logic               pending_q, pending_d;
  logic               ack_q, ack_d;
  logic               pstart_q, pstart_d;

  logic boundary;
  logic commit;
  logic load;

  always_comb begin
    // A center period with max==1 is just 0,1 so the top is also the boundary.
    if (max_q == '0) begin
      boundary = 1'b1;
    end else if (mode_q == PwmEdge) begin
      boundary = (cnt_q == max_q);
    end else begin
      boundary = ((dir_q == CntDown) && (cnt_q == One)) ||
                 ((dir_q == CntUp) && (cnt_q == max_q) && (max_q == One));
    end

    commit = enable_i && boundary && (pending_q || update_i);
    load   = !enable_i || commit;

    mode_d = load ? pwm_mode_e'(center_i) : mode_q;
    max_d  = load ? max_counter_i : max_q;

    cnt_d = '0;
    dir_d = CntUp;
    if (enable_i && !boundary) begin
      if (mode_q == PwmEdge) begin
        cnt_d = cnt_q + One;
      end else if (dir_q == CntUp) begin
        if (cnt_q == max_q) begin
          cnt_d = cnt_q - One;
          dir_d = CntDown;
        end else begin
          cnt_d = cnt_q + One;
        end
      end else begin
        cnt_d = cnt_q - One;
        dir_d = CntDown;
      end
    end

    if (!enable_i || commit) begin
      pending_d = 1'b0;
    end else if (update_i) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end

    ack_d    = commit;
    // Counter 0 only occurs at a period start in both modes.
    pstart_d = enable_i && (cnt_q == '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      max_q     <= '0;
      dir_q     <= CntUp;
      mode_q    <= PwmEdge;
      pending_q <= 1'b0;
      ack_q     <= 1'b0;
      pstart_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      max_q     <= max_d;
      dir_q     <= dir_d;
      mode_q    <= mode_d;
      pending_q <= pending_d;
      ack_q     <= ack_d;
      pstart_q  <= pstart_d;
    end
  end

  assign update_ack_o   = ack_q;
  assign period_start_o = pstart_q;

  for (genvar gi = 0; gi < NumChannels; gi++) begin : g_chan
    pwm_chan #(
      .CtrSize(CtrSize)
    ) u_chan (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .load_i  (load),
      .run_i   (enable_i),
      .count_i (cnt_q),
      .width_i (pulse_width_i[gi]),
      .invert_i(invert_i[gi]),
      .out_o   (modulated_o[gi])
    );
  end

endmodule

// File: tb/tb_pwm_mc.sv
// Directed bench for pwm_mc: edge/center patterns, boundary updates, max==0,
// disabled idle levels and reset discarding a pending update.
module tb_pwm_mc;

  logic                 clk;
  logic                 rst;
  logic                 enable;
  logic                 center;
  logic [7:0]           maxc;
  logic [3:0][7:0]      pw;
  logic [3:0]           inv;
  logic                 upd;
  logic                 ack;
  logic                 ps;
  logic [3:0]           mod;

  int total = 0;
  int bad   = 0;

  pwm_mc #(
    .NumChannels(4),
    .CtrSize    (8)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .enable_i      (enable),
    .center_i      (center),
    .max_counter_i (maxc),
    .pulse_width_i (pw),
    .invert_i      (inv),
    .update_i      (upd),
    .update_ack_o  (ack),
    .period_start_o(ps),
    .modulated_o   (mod)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s got=%0h", tag, got);
    end
  endtask

  initial begin
    logic [4:0] pat_w2;
    logic [4:0] pat_w4;
    logic [7:0] pat_ctr;
    pat_w2  = 5'b00011;
    pat_w4  = 5'b01111;
    pat_ctr = 8'b1000_0011;

    rst = 1'b1; enable = 1'b0; center = 1'b0; maxc = 8'd0;
    pw = '0; inv = 4'b0; upd = 1'b0;
    tick(); tick();
    check("rst_mod", 32'(mod), 32'h0);
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_ps",  32'(ps),  32'h0);
    rst = 1'b0;

    // Edge mode, max=4, width0=2
    maxc = 8'd4; pw[0] = 8'd2;
    tick(); tick();
    check("dis_mod", 32'(mod), 32'h0);
    check("dis_ps",  32'(ps),  32'h0);
    enable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("edge_mod k=%0d", k), 32'(mod[0]), 32'(pat_w2[k % 5]));
      check($sformatf("edge_ps k=%0d", k),  32'(ps), 32'((k % 5) == 0));
    end

    // Center mode, max=4, width0=2
    enable = 1'b0; center = 1'b1;
    tick(); tick();
    enable = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      check($sformatf("ctr_mod k=%0d", k), 32'(mod[0]), 32'(pat_ctr[k % 8]));
      check($sformatf("ctr_ps k=%0d", k),  32'(ps), 32'((k % 8) == 0));
    end

    // Mid-period update to width 4, then an update landing on the boundary cycle
    enable = 1'b0; center = 1'b0; pw[0] = 8'd2;
    tick(); tick();
    enable = 1'b1;
    tick();
    check("upd_pre0", 32'(mod[0]), 32'h1);
    tick();
    check("upd_pre1", 32'(mod[0]), 32'h1);
    pw[0] = 8'd4; upd = 1'b1;
    tick();
    upd = 1'b0;
    check("upd_old2", 32'(mod[0]), 32'h0);
    check("upd_ack2", 32'(ack), 32'h0);
    tick();
    check("upd_old3", 32'(mod[0]), 32'h0);
    check("upd_ack3", 32'(ack), 32'h0);
    tick();
    check("upd_old4", 32'(mod[0]), 32'h0);
    check("upd_ack",  32'(ack), 32'h1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("upd_new k=%0d", k), 32'(mod[0]), 32'(pat_w4[k]));
      check($sformatf("upd_noack k=%0d", k), 32'(ack), 32'h0);
    end
    tick(); tick(); tick(); tick();
    pw[0] = 8'd1; upd = 1'b1;
    tick();
    upd = 1'b0;
    check("bnd_ack", 32'(ack), 32'h1);
    tick();
    check("bnd_mod0", 32'(mod[0]), 32'h1);
    check("bnd_ack_off", 32'(ack), 32'h0);
    tick();
    check("bnd_mod1", 32'(mod[0]), 32'h0);

    // max=0: every cycle is a boundary, channel 1 inverted with width 0
    enable = 1'b0; maxc = 8'd0; pw[0] = 8'd1; pw[1] = 8'd0; inv = 4'b0010;
    tick(); tick();
    check("m0_dis_mod", 32'(mod), 32'h2);
    enable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("m0_mod k=%0d", k), 32'(mod), 32'h3);
      check($sformatf("m0_ps k=%0d", k),  32'(ps), 32'h1);
    end

    // Reset mid-period with an update pending
    enable = 1'b0; maxc = 8'd4; pw[0] = 8'd2; inv = 4'b0;
    tick(); tick();
    enable = 1'b1;
    tick(); tick();
    pw[0] = 8'd3; upd = 1'b1;
    tick();
    upd = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("rr_mod", 32'(mod), 32'h0);
    check("rr_ack", 32'(ack), 32'h0);
    check("rr_ps",  32'(ps),  32'h0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("rr_zero_mod k=%0d", k), 32'(mod), 32'h0);
      check($sformatf("rr_noack k=%0d", k), 32'(ack), 32'h0);
      check($sformatf("rr_ps k=%0d", k), 32'(ps), 32'h1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
